// File: rtl/mem_lsu.sv
// mem_lsu: multi-cycle load/store initiator with read-modify-write sub-word stores and error flagging.
// Defining MEM_LSU_BIG_ENDIAN_EN selects big-endian byte/half lanes; the default build is little-endian.
module mem_lsu #(
  parameter int MEM_WORDS = 128
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] resp_rdata,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);
  typedef enum logic [2:0] {IDLE, LOAD, STORE, RMW_RD, RMW_WR, RESP} state_t;
  state_t      state_q;
  logic [1:0]  off_q, size_q;
  logic        uns_q, req_ready_q, resp_valid_q, resp_err_q, mem_we_q, bad;
  logic [31:0] wdata_q, resp_rdata_q, mem_addr_q, mem_wdata_q, ext, mask, merged;
  logic [15:0] lane;
  logic [4:0]  sh;
  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  // sh is the bit position of the addressed byte/half lane inside the word
  always_comb begin
`ifdef MEM_LSU_BIG_ENDIAN_EN
    sh = size_q == 2'b00 ? {~off_q, 3'b000} : {~off_q[1], 4'b0000};
`else
    sh = size_q == 2'b00 ? {off_q, 3'b000} : {off_q[1], 4'b0000};
`endif
    lane = 16'(mem_rdata >> sh);
    ext = size_q == 2'b00 ? {{24{lane[7] & ~uns_q}}, lane[7:0]}
        : size_q == 2'b01 ? {{16{lane[15] & ~uns_q}}, lane} : mem_rdata;
    mask = (size_q == 2'b00 ? 32'h0000_00ff : 32'h0000_ffff) << sh;
    merged = (mem_rdata & ~mask) | ((wdata_q << sh) & mask);
    bad = (req_size == 2'b11) | ((req_size == 2'b01) & req_addr[0])
        | ((req_size == 2'b10) & (|req_addr[1:0])) | (req_addr[31:2] >= 30'(MEM_WORDS));
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      off_q        <= '0;
      size_q       <= '0;
      uns_q        <= 1'b0;
      wdata_q      <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
    end else begin
      case (state_q)
        IDLE: if (req_valid) begin
          off_q       <= req_addr[1:0];
          size_q      <= req_size;
          uns_q       <= req_unsigned;
          wdata_q     <= req_wdata;
          mem_addr_q  <= {req_addr[31:2], 2'b00};
          req_ready_q <= 1'b0;
          if (bad) begin
            state_q      <= RESP;
            resp_valid_q <= 1'b1;
            resp_err_q   <= 1'b1;
          end else if (!req_write) begin
            state_q <= LOAD;
          end else if (req_size == 2'b10) begin
            state_q     <= STORE;
            mem_we_q    <= 1'b1;
            mem_wdata_q <= req_wdata;
          end else begin
            state_q <= RMW_RD;
          end
        end
        LOAD: begin
          resp_rdata_q <= ext;
          resp_valid_q <= 1'b1;
          state_q      <= RESP;
        end
        RMW_RD: begin
          mem_we_q    <= 1'b1;
          mem_wdata_q <= merged;
          state_q     <= RMW_WR;
        end
        STORE, RMW_WR: begin
          mem_we_q     <= 1'b0;
          mem_wdata_q  <= '0;
          resp_valid_q <= 1'b1;
          state_q      <= RESP;
        end
        RESP: begin
          resp_valid_q <= 1'b0;
          resp_err_q   <= 1'b0;
          req_ready_q  <= 1'b1;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_lsu.sv
// tb_mem_lsu: scoreboard bench for mem_lsu with a byte-level reference model and a behavioural data memory.
module tb_mem_lsu;
  logic        clk, reset, req_valid, req_ready, req_write, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata, resp_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        resp_valid, resp_err, mem_we, load_mem;
  logic [31:0] mem [128];
  logic [31:0] seed [128];
  logic [31:0] ref_mem [128];
  logic [31:0] ref_rd, last_rdata;
  logic        last_err;
  int          cyc = 0, errors = 0, checks = 0;

  typedef struct {logic err; logic [31:0] rdata; int acc; int lat;} sb_t;
  typedef struct {logic [31:0] addr; logic [31:0] data;} wr_t;
  sb_t sbq[$];
  wr_t wq[$];

  mem_lsu dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_err(resp_err), .resp_rdata(resp_rdata), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial clk = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign mem_rdata = mem[mem_addr[8:2]];
  always @(posedge clk)
    if (load_mem) for (int i = 0; i < 128; i++) mem[i] <= seed[i];
    else if (mem_we) mem[mem_addr[8:2]] <= mem_wdata;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int nbytes(input logic [1:0] sz);
    return sz == 2'd0 ? 1 : sz == 2'd1 ? 2 : 4;
  endfunction

  function automatic int lane_shift(input logic [31:0] a, input int n);
`ifdef MEM_LSU_BIG_ENDIAN_EN
    return 8 * (4 - n - int'(a[1:0]));
`else
    return 8 * int'(a[1:0]);
`endif
  endfunction

  function automatic logic is_err(input logic [31:0] a, input logic [1:0] sz);
    return sz == 2'd3 || (a % 32'(nbytes(sz))) != 0 || (a >> 2) >= 32'd128;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [31:0] a,
                                           input logic [1:0] sz, input logic u);
    int n;
    logic [63:0] full, v;
    n = nbytes(sz);
    full = (64'd1 << (8 * n)) - 64'd1;
    v = ({32'd0, w} >> lane_shift(a, n)) & full;
    if (!u && n < 4 && v[8*n-1]) v = v | ~full;
    return v[31:0];
  endfunction

  function automatic logic [31:0] ref_store(input logic [31:0] w, input logic [31:0] a,
                                            input logic [1:0] sz, input logic [31:0] wd);
    int n, s;
    logic [63:0] full, v;
    n = nbytes(sz);
    s = lane_shift(a, n);
    full = ((64'd1 << (8 * n)) - 64'd1) << s;
    v = ({32'd0, w} & ~full) | (({32'd0, wd} << s) & full);
    return v[31:0];
  endfunction

  // Monitor + model: samples on the falling edge, between driver updates and DUT edges
  always @(negedge clk) if (!reset) begin
    sb_t e;
    wr_t w;
    int idx;
    chk("req_ready", req_ready, sbq.size() == 0);
    if (!mem_we) chk("mem_wdata_idle", mem_wdata, 0);
    else if (wq.size() == 0) chk("unexpected_mem_we", mem_we, 0);
    else begin
      w = wq.pop_front();
      chk("mem_addr", mem_addr, w.addr);
      chk("mem_wdata", mem_wdata, w.data);
    end
    if (resp_valid) begin
      if (sbq.size() == 0) chk("unexpected_resp", resp_valid, 0);
      else begin
        e = sbq.pop_front();
        chk("resp_err", resp_err, e.err);
        chk("resp_rdata", resp_rdata, e.rdata);
        chk("latency", cyc - e.acc, e.lat);
        last_rdata = resp_rdata;
        last_err = resp_err;
      end
    end else chk("resp_err_idle", resp_err, 0);
    if (req_valid && req_ready) begin
      e.err = is_err(req_addr, req_size);
      e.acc = cyc;
      idx = int'(req_addr[8:2]);
      if (e.err) e.lat = 1;
      else if (req_write) begin
        ref_mem[idx] = ref_store(ref_mem[idx], req_addr, req_size, req_wdata);
        wq.push_back('{{req_addr[31:2], 2'b00}, ref_mem[idx]});
        e.lat = req_size == 2'd2 ? 2 : 3;
      end else begin
        ref_rd = ref_load(ref_mem[idx], req_addr, req_size, req_unsigned);
        e.lat = 2;
      end
      e.rdata = ref_rd;
      sbq.push_back(e);
    end
  end

  task automatic issue(input logic w, input logic [1:0] sz, input logic u,
                       input logic [31:0] a, input logic [31:0] wd);
    int n = 0;
    req_valid = 1; req_write = w; req_size = sz; req_unsigned = u; req_addr = a; req_wdata = wd;
    do begin @(negedge clk); n++; end while (!req_ready && n < 20);
    chk("accept_timeout", req_ready, 1);
    @(posedge clk); #1;
    req_valid = 0; req_addr = $urandom; req_wdata = $urandom; req_size = 2'($urandom);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 20 && sbq.size() != 0; i++) @(posedge clk);
    #1;
    chk("resp_timeout", sbq.size(), 0);
  endtask

  initial begin
    reset = 1; load_mem = 1; req_valid = 0; req_write = 0; req_size = 0; req_unsigned = 0;
    req_addr = 0; req_wdata = 0; ref_rd = 0; last_rdata = 0; last_err = 0;
    for (int i = 0; i < 128; i++) seed[i] = $urandom;
    seed[3] = 32'h80FF7F01;
    seed[5] = 32'h11223344;
    for (int i = 0; i < 128; i++) ref_mem[i] = seed[i];
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", req_ready, 1);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_err", resp_err, 0);
    chk("rst_resp_rdata", resp_rdata, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    load_mem = 0; reset = 0;
    @(posedge clk); #1;
`ifdef MEM_LSU_BIG_ENDIAN_EN
    issue(0, 2'd0, 0, 32'h0D, 0); wait_done(); chk("lb_0d", last_rdata, 32'hFFFFFFFF);
    issue(0, 2'd1, 0, 32'h0E, 0); wait_done(); chk("lh_0e", last_rdata, 32'h00007F01);
    issue(0, 2'd1, 1, 32'h0E, 0); wait_done(); chk("lhu_0e", last_rdata, 32'h00007F01);
    issue(1, 2'd0, 0, 32'h16, 32'hAB); wait_done(); chk("sb_16_mem", mem[5], 32'h1122AB44);
`else
    issue(0, 2'd0, 0, 32'h0D, 0); wait_done(); chk("lb_0d", last_rdata, 32'h0000007F);
    issue(0, 2'd1, 0, 32'h0E, 0); wait_done(); chk("lh_0e", last_rdata, 32'hFFFF80FF);
    issue(0, 2'd1, 1, 32'h0E, 0); wait_done(); chk("lhu_0e", last_rdata, 32'h000080FF);
    issue(1, 2'd0, 0, 32'h16, 32'hAB); wait_done(); chk("sb_16_mem", mem[5], 32'h11AB3344);
`endif
    issue(1, 2'd2, 0, 32'h1002, 32'h12345678); wait_done(); chk("sw_misaligned_err", last_err, 1);
    issue(0, 2'd2, 0, 32'h200, 0); wait_done(); chk("lw_range_err", last_err, 1);
    issue(0, 2'd3, 0, 32'h40, 0); wait_done(); chk("size3_err", last_err, 1);
    // Abort a halfword RMW while the DUT sits in its read phase
    req_valid = 1; req_write = 1; req_size = 2'd1; req_unsigned = 0; req_addr = 32'h20; req_wdata = 32'h5A5A;
    @(posedge clk); #1;
    req_valid = 0;
    reset = 1;
    #1;
    chk("midrst_mem_we", mem_we, 0);
    chk("midrst_req_ready", req_ready, 1);
    chk("midrst_resp_valid", resp_valid, 0);
    sbq.delete(); wq.delete();
    ref_mem[8] = seed[8]; ref_rd = 0;
    @(posedge clk); #1;
    reset = 0;
    repeat (4) @(posedge clk); #1;
    chk("midrst_word8", mem[8], seed[8]);
    issue(1, 2'd2, 0, 32'h04, 32'hDEADBEEF);
    issue(0, 2'd2, 0, 32'h04, 0);
    wait_done();
    chk("b2b_lw", last_rdata, 32'hDEADBEEF);
    for (int k = 0; k < 300; k++) begin
      logic [31:0] a;
      a = $urandom_range(0, 15) == 0 ? $urandom : (32'($urandom_range(0, 130)) << 2) | 32'($urandom_range(0, 3));
      issue(1'($urandom), 2'($urandom), 1'($urandom), a, $urandom);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    wait_done();
    repeat (2) @(posedge clk); #1;
    for (int i = 0; i < 128; i++) if (mem[i] !== ref_mem[i]) chk($sformatf("final_mem[%0d]", i), mem[i], ref_mem[i]);
    chk("final_mem_word3", mem[3], ref_mem[3]);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
